seq_shift_unit: RTL and testbench

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

---
 rtl/shift_pkg.sv | 33 +++
 rtl/shift_step.sv | 40 ++++
 rtl/seq_shift_unit.sv | 128 ++++++++++++
 tb/tb_seq_shift_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit: opcode enum, FSM state and opcode legality.
// ROL/ROR count as legal only when SHIFT_ROTATE_EN is defined.
package shift_pkg;

    typedef enum logic [2:0] {
        SHIFT_SLL = 3'd0,
        SHIFT_SRL = 3'd1,
        SHIFT_SRA = 3'd2,
        SHIFT_ROL = 3'd3,
        SHIFT_ROR = 3'd4
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Opcodes 5..7 are never legal; rotates depend on the build.
    function automatic logic op_illegal(input logic [2:0] op);
        logic ill;
        ill = 1'b1;
        case (op)
            SHIFT_SLL, SHIFT_SRL, SHIFT_SRA: ill = 1'b0;
`ifdef SHIFT_ROTATE_EN
            SHIFT_ROL, SHIFT_ROR:            ill = 1'b0;
`endif
            default:                         ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: moves a WIDTH-bit value by 'amt' positions for the given op.
// Rotate paths exist only when SHIFT_ROTATE_EN is defined; other opcodes pass data through.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]       data,
    input  logic [$clog2(WIDTH):0] amt,
    input  logic [2:0]             op,
    input  logic                   fill,
    output logic [WIDTH-1:0]       result
);

    localparam int AW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] vacated_hi;

`ifdef SHIFT_ROTATE_EN
    logic [AW-1:0] rot_back;
    // For amt == 0 the back shift is by WIDTH, which yields zero, so rotate-by-0 is identity.
    assign rot_back = AW'(WIDTH) - amt;
`endif

    always_comb begin
        vacated_hi = ~({WIDTH{1'b1}} >> amt);
        result     = data;
        case (op)
            SHIFT_SLL: result = data << amt;
            SHIFT_SRL: result = data >> amt;
            SHIFT_SRA: result = (data >> amt) | (fill ? vacated_hi : '0);
`ifdef SHIFT_ROTATE_EN
            SHIFT_ROL: result = (data << amt) | (data >> rot_back);
            SHIFT_ROR: result = (data >> amt) | (data << rot_back);
`endif
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle barrel-less shifter: shifts by up to STEP positions per cycle with a valid/ready front and back.
// Define SHIFT_ROTATE_EN to build ROL/ROR; otherwise those opcodes report out_err like any illegal op.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [$clog2(WIDTH):0] in_shamt,
    input  logic [2:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_err
);

    localparam int            AW      = $clog2(WIDTH) + 1;
    localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);
    localparam logic [AW-1:0] STEP_A  = AW'(STEP);

    // Handshake: a transfer happens on a rising edge where valid && ready; in_ready is
    // high only in IDLE, out_valid only in DONE, and DONE holds its result until taken.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic             err_q, err_d;
    logic             fill_q, fill_d;

    logic             in_illegal;
    logic             in_rotate;
    logic [AW-1:0]    eff_amt;
    logic [AW-1:0]    step_amt;
    logic [WIDTH-1:0] step_result;

    // Rotates wrap modulo WIDTH; linear shifts clamp at WIDTH so the result fully drains.
    always_comb begin
        in_illegal = op_illegal(in_op);
`ifdef SHIFT_ROTATE_EN
        in_rotate  = (in_op == SHIFT_ROL) || (in_op == SHIFT_ROR);
`else
        in_rotate  = 1'b0;
`endif
        if (in_rotate) begin
            eff_amt = {1'b0, in_shamt[AW-2:0]};
        end else if (in_shamt >= WIDTH_A) begin
            eff_amt = WIDTH_A;
        end else begin
            eff_amt = in_shamt;
        end
    end

    assign step_amt = (rem_q < STEP_A) ? rem_q : STEP_A;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data   (data_q),
        .amt    (step_amt),
        .op     (op_q),
        .fill   (fill_q),
        .result (step_result)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        op_d      = op_q;
        rem_d     = rem_q;
        err_d     = err_q;
        fill_d    = fill_q;
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    op_d    = in_op;
                    fill_d  = in_data[WIDTH-1];
                    err_d   = in_illegal;
                    rem_d   = in_illegal ? '0 : eff_amt;
                    state_d = (in_illegal || (eff_amt == '0)) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = step_result;
                rem_d  = rem_q - step_amt;
                if (rem_q == step_amt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
        end
    end

    assign out_data = data_q;
    assign out_err  = err_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit (WIDTH=32, STEP=4): bit-level reference model, expected queue and per-cycle monitor.
// Honors SHIFT_ROTATE_EN the same way the design does.
module tb_seq_shift_unit;

    localparam int W    = 32;
    localparam int STEP = 4;
    localparam int SW   = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_shamt;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_err;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           lat;
        int           acc;
        bit           seen;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   rdy_mode = 1;

    seq_shift_unit #(.WIDTH(W), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Consumer: 0 = stall, 1 = always ready, otherwise random back-pressure.
    initial forever begin
        @(posedge clk);
        #2;
        if (rdy_mode == 0)      out_ready = 1'b0;
        else if (rdy_mode == 1) out_ready = 1'b1;
        else                    out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each result bit is picked from its source position by the op's rule.
    function automatic void model(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [2:0] op,
                                  output logic [W-1:0] r, output logic e, output int lat);
        int  amt;
        int  src;
        bit  legal;
        legal = (op <= 3'd2);
`ifdef SHIFT_ROTATE_EN
        legal = legal || (op == 3'd3) || (op == 3'd4);
`endif
        r   = d;
        e   = !legal;
        lat = 1;
        if (!legal) return;
        if (op >= 3'd3) amt = int'(sh) % W;
        else            amt = (int'(sh) > W) ? W : int'(sh);
        for (int i = 0; i < W; i++) begin
            if (op == 3'd0) begin
                src = i - amt;
                r[i] = (src >= 0) ? d[src] : 1'b0;
            end else if (op == 3'd1 || op == 3'd2) begin
                src = i + amt;
                if (src < W) r[i] = d[src];
                else         r[i] = (op == 3'd2) ? d[W-1] : 1'b0;
            end else if (op == 3'd3) begin
                r[i] = d[(i - amt + W) % W];
            end else begin
                r[i] = d[(i + amt) % W];
            end
        end
        lat = (amt + STEP - 1) / STEP + 1;
    endfunction

    task automatic pin(input string name, input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [2:0] op,
                       input logic [W-1:0] exp_d, input logic exp_e, input int exp_lat);
        logic [W-1:0] r;
        logic         e;
        int           lat;
        model(d, sh, op, r, e, lat);
        chk({name, "_model_data"}, 64'(r), 64'(exp_d));
        chk({name, "_model_err"}, 64'(e), 64'(exp_e));
        chk({name, "_model_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [2:0] op);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_op    = op;
        model(d, sh, op, e.data, e.err, e.lat);
        e.acc  = cycle;
        e.seen = 0;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = SW'($urandom);
        in_op    = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every DONE cycle is compared with the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("ready_valid_exclusive", 64'(in_ready && out_valid), 64'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_valid: out_valid=1 with no request outstanding (t=%0t)", $time);
                end else begin
                    if (!exp_q[0].seen) begin
                        chk("latency", 64'(cycle - exp_q[0].acc), 64'(exp_q[0].lat));
                        exp_q[0].seen = 1;
                    end
                    chk("out_data", 64'(out_data), 64'(exp_q[0].data));
                    chk("out_err", 64'(out_err), 64'(exp_q[0].err));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int  n;
        bit  seen_valid;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_shamt = '0;
        in_op    = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_err", 64'(out_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        pin("sll9", 32'h0000_0001, 6'd9, 3'd0, 32'h0000_0200, 1'b0, 4);
        pin("sra40", 32'h8000_0000, 6'd40, 3'd2, 32'hFFFF_FFFF, 1'b0, 9);
        pin("srl40", 32'h8000_0000, 6'd40, 3'd1, 32'h0000_0000, 1'b0, 9);
`ifdef SHIFT_ROTATE_EN
        pin("ror36", 32'h0000_00F1, 6'd36, 3'd4, 32'h1000_000F, 1'b0, 2);
        pin("rol8", 32'h1234_5678, 6'd8, 3'd3, 32'h3456_7812, 1'b0, 3);
`else
        pin("ror36", 32'h0000_00F1, 6'd36, 3'd4, 32'h0000_00F1, 1'b1, 1);
`endif
        pin("op6", 32'h1234_5678, 6'd5, 3'd6, 32'h1234_5678, 1'b1, 1);
        pin("sll0", 32'hDEAD_BEEF, 6'd0, 3'd0, 32'hDEAD_BEEF, 1'b0, 1);

        send(32'h0000_0001, 6'd9, 3'd0);  drain();
        send(32'h8000_0000, 6'd40, 3'd2); drain();
        send(32'h8000_0000, 6'd40, 3'd1); drain();
        send(32'h0000_00F1, 6'd36, 3'd4); drain();
        send(32'h1234_5678, 6'd8, 3'd3);  drain();
        send(32'h1234_5678, 6'd5, 3'd6);  drain();
        send(32'hDEAD_BEEF, 6'd0, 3'd0);  drain();
        send(32'h8765_4321, 6'd32, 3'd2); drain();

        // Consumer stall: result must sit in DONE unchanged, then leave on the edge after ready.
        rdy_mode = 0;
        send(32'hA5A5_0F0F, 6'd13, 3'd1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        rdy_mode = 1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_valid_while_ready", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset in the middle of a long SLL must drop the operation.
        send(32'h0000_0001, 6'd31, 3'd0);
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 64'(in_ready), 64'd0);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_reset_in_ready", 64'(in_ready), 64'd1);
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_midshift_reset", 64'(in_ready), 64'd1);
        seen_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1;
        end
        chk("no_result_after_reset", 64'(seen_valid), 64'd0);

        // Random traffic with back-pressure.
        rdy_mode = 2;
        repeat (150) begin
            logic [2:0]    op;
            logic [SW-1:0] sh;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            sh = ($urandom_range(0, 1) == 0) ? SW'($urandom_range(0, W)) : SW'($urandom);
            send($urandom, sh, op);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
